// File: rtl/framebuffer_fragment_port_if.sv
// Per-fragment read/write-back/clear bundle between a fragment pipeline (master)
// and one framebuffer responder (slave).
interface framebuffer_fragment_port_if #(
  parameter int INDEX_WIDTH = 14,
  parameter int DATA_WIDTH  = 32
);
  logic                   req_tvalid;
  logic                   req_tready;
  logic [INDEX_WIDTH-1:0] req_tindex;
  logic                   rvalid;
  logic                   rready;
  logic [DATA_WIDTH-1:0]  rdata;
  logic [INDEX_WIDTH-1:0] waddr;
  logic                   wvalid;
  logic                   wlast;
  logic [DATA_WIDTH-1:0]  wdata;
  logic                   wstrb;
  logic                   clear_start;
  logic [DATA_WIDTH-1:0]  clear_value;
  logic                   clear_busy;
  logic                   frame_done;
  logic                   order_error;
  logic [1:0]             fsm_state;

  modport master (
    output req_tvalid, req_tindex, rready, waddr, wvalid, wlast, wdata, wstrb,
           clear_start, clear_value,
    input  req_tready, rvalid, rdata, clear_busy, frame_done, order_error, fsm_state
  );

  modport slave (
    input  req_tvalid, req_tindex, rready, waddr, wvalid, wlast, wdata, wstrb,
           clear_start, clear_value,
    output req_tready, rvalid, rdata, clear_busy, frame_done, order_error, fsm_state
  );
endinterface

// File: rtl/framebuffer_fragment_port.sv
// On-chip framebuffer responder: ordered index reads with RAW-hazard stalling against
// pending write-backs, in-order write-back retirement, and whole-buffer clear.
module framebuffer_fragment_port #(
  parameter int INDEX_WIDTH  = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 8
) (
  input logic                        aclk,
  input logic                        reset,
  framebuffer_fragment_port_if.slave fb
);
  localparam int DEPTH = 2**INDEX_WIDTH;
  localparam int PTR_W = $clog2(MAX_INFLIGHT);

  typedef enum logic [1:0] {RUN = 2'd0, CLEAR_WAIT = 2'd1, CLEAR = 2'd2} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  ram_q;
  logic                   ram_valid;

  logic [INDEX_WIDTH-1:0] sb_idx [MAX_INFLIGHT];
  logic [MAX_INFLIGHT-1:0] sb_valid;
  logic [PTR_W-1:0]       sb_wr, sb_rd;
  logic [PTR_W:0]         sb_cnt;

  logic [DATA_WIDTH-1:0]  ob_data [2];
  logic                   ob_wr, ob_rd;
  logic [1:0]             ob_cnt;

  logic [DATA_WIDTH-1:0]  clr_val;
  logic [INDEX_WIDTH-1:0] clr_addr;

  logic hazard, sb_full, sb_empty, room, req_fire, sb_pop, ob_push, ob_pop;
  logic clr_last, wb_bad, mem_we;
  logic [INDEX_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;

  // A request is checked against every pending write-back, including the one retiring
  // this cycle, so a read always samples memory after the matching write has landed.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < MAX_INFLIGHT; i++) begin
      if (sb_valid[i] && (sb_idx[i] == fb.req_tindex)) hazard = 1'b1;
    end
  end

  assign sb_full  = (sb_cnt == (PTR_W+1)'(MAX_INFLIGHT));
  assign sb_empty = (sb_cnt == '0);
  // Reads already in the RAM stage plus buffered words may never exceed the skid depth.
  assign room     = (ob_cnt == 2'd0) || ((ob_cnt == 2'd1) && !ram_valid);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // valid never waits on ready, and rvalid/rdata hold until taken.
  assign fb.req_tready = !reset && (state == RUN) && !hazard && !sb_full && room;
  assign req_fire      = fb.req_tvalid && fb.req_tready;

  assign sb_pop   = fb.wvalid && !sb_empty;
  assign wb_bad   = fb.wvalid && (sb_empty || (fb.waddr != sb_idx[sb_rd]) || (state == CLEAR));
  assign ob_push  = ram_valid;
  assign ob_pop   = (ob_cnt != 2'd0) && fb.rready;
  assign clr_last = (clr_addr == {INDEX_WIDTH{1'b1}});

  assign mem_we    = (state == CLEAR) || (fb.wvalid && fb.wstrb && !reset);
  assign mem_waddr = (state == CLEAR) ? clr_addr : fb.waddr;
  assign mem_wdata = (state == CLEAR) ? clr_val  : fb.wdata;

  assign fb.rvalid     = (ob_cnt != 2'd0);
  assign fb.rdata      = (ob_cnt != 2'd0) ? ob_data[ob_rd] : '0;
  assign fb.clear_busy = (state != RUN);
  assign fb.fsm_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:        if (fb.clear_start) state_nxt = CLEAR_WAIT;
      CLEAR_WAIT: if (sb_empty && (ob_cnt == 2'd0) && !ram_valid) state_nxt = CLEAR;
      CLEAR:      if (clr_last) state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  // Storage and datapath registers carry no reset; memory survives reset.
  always_ff @(posedge aclk) begin
    if (mem_we)   mem[mem_waddr] <= mem_wdata;
    if (req_fire) ram_q <= mem[fb.req_tindex];
    if (req_fire) sb_idx[sb_wr] <= fb.req_tindex;
    if (ob_push)  ob_data[ob_wr] <= ram_q;
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      sb_valid       <= '0;
      sb_wr          <= '0;
      sb_rd          <= '0;
      sb_cnt         <= '0;
      ob_wr          <= 1'b0;
      ob_rd          <= 1'b0;
      ob_cnt         <= 2'd0;
      ram_valid      <= 1'b0;
      clr_val        <= '0;
      clr_addr       <= '0;
      fb.frame_done  <= 1'b0;
      fb.order_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      ram_valid <= req_fire;
      if (req_fire) begin
        sb_valid[sb_wr] <= 1'b1;
        sb_wr           <= sb_wr + 1'b1;
      end
      if (sb_pop) begin
        sb_valid[sb_rd] <= 1'b0;
        sb_rd           <= sb_rd + 1'b1;
      end
      sb_cnt <= sb_cnt + (PTR_W+1)'(req_fire) - (PTR_W+1)'(sb_pop);
      if (ob_push) ob_wr <= ~ob_wr;
      if (ob_pop)  ob_rd <= ~ob_rd;
      ob_cnt <= ob_cnt + 2'(ob_push) - 2'(ob_pop);
      if ((state == RUN) && fb.clear_start) clr_val <= fb.clear_value;
      if (state == CLEAR_WAIT)  clr_addr <= '0;
      else if (state == CLEAR)  clr_addr <= clr_addr + 1'b1;
      fb.frame_done  <= fb.wvalid && fb.wlast;
      fb.order_error <= fb.order_error || wb_bad;
    end
  end
endmodule

// File: tb/tb_framebuffer_fragment_port.sv
// Directed bench for framebuffer_fragment_port: reads are scored against an expected-data
// queue filled at request acceptance and drained when rvalid & rready is seen.
module tb_framebuffer_fragment_port;
  localparam int IW    = 14;
  localparam int DW    = 32;
  localparam int NI    = 8;
  localparam int DEPTH = 2**IW;

  logic aclk = 1'b0;
  logic reset;
  always #5 aclk = ~aclk;

  framebuffer_fragment_port_if #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW)) ifc ();

  framebuffer_fragment_port #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .MAX_INFLIGHT(NI)) dut (
    .aclk  (aclk),
    .reset (reset),
    .fb    (ifc)
  );

  int checks = 0;
  int errors = 0;
  int acc_count = 0;
  int base = 0;
  int n = 0;
  logic [DW-1:0] exp_q[$];
  bit            chk_q[$];
  logic [DW-1:0] mon_e;
  bit            mon_c;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  function automatic logic [DW-1:0] pat(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  // Scoreboard side: pop one expectation per consumed word; check hold while stalled.
  always @(negedge aclk) begin
    if (!reset) begin
      if (prev_stall) begin
        chk("hold_rvalid", 32'(ifc.rvalid), 32'd1);
        chk("hold_rdata", ifc.rdata, prev_data);
      end
      if (ifc.rvalid && ifc.rready) begin
        chk("rvalid_has_exp", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_c = chk_q.pop_front();
          if (mon_c) chk("rdata", ifc.rdata, mon_e);
        end
      end
      prev_stall = ifc.rvalid && !ifc.rready;
      prev_data  = ifc.rdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Hold a request until accepted; the expectation is queued in acceptance order.
  task automatic do_req(input logic [IW-1:0] idx, input bit check, input logic [DW-1:0] exp);
    int  waited;
    bit  done;
    waited = 0;
    done   = 1'b0;
    ifc.req_tvalid = 1'b1;
    ifc.req_tindex = idx;
    while (!done && waited < 300) begin
      @(negedge aclk);
      if (ifc.req_tready) begin
        exp_q.push_back(exp);
        chk_q.push_back(check);
        acc_count++;
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge aclk); #1;
    end
    ifc.req_tvalid = 1'b0;
    chk("req_accepted", 32'(done), 32'd1);
  endtask

  task automatic wb(input logic [IW-1:0] a, input logic [DW-1:0] d, input logic s, input logic l);
    ifc.waddr  = a;
    ifc.wdata  = d;
    ifc.wstrb  = s;
    ifc.wlast  = l;
    ifc.wvalid = 1'b1;
    @(posedge aclk); #1;
    ifc.wvalid = 1'b0;
    ifc.wstrb  = 1'b0;
    ifc.wlast  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge aclk);
      k++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge aclk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.req_tvalid = 1'b0; ifc.req_tindex = '0; ifc.rready = 1'b0;
    ifc.waddr = '0; ifc.wvalid = 1'b0; ifc.wlast = 1'b0; ifc.wdata = '0; ifc.wstrb = 1'b0;
    ifc.clear_start = 1'b0; ifc.clear_value = '0;
    reset = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_req_tready",  32'(ifc.req_tready),  32'd0);
    chk("rst_rvalid",      32'(ifc.rvalid),      32'd0);
    chk("rst_rdata",       ifc.rdata,            32'd0);
    chk("rst_clear_busy",  32'(ifc.clear_busy),  32'd0);
    chk("rst_frame_done",  32'(ifc.frame_done),  32'd0);
    chk("rst_order_error", 32'(ifc.order_error), 32'd0);
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    chk("idle_req_tready", 32'(ifc.req_tready), 32'd1);
    @(posedge aclk); #1;

    // 1: write 5 via request/write-back, then read it back with latency check
    ifc.rready = 1'b1;
    do_req(14'd5, 1'b0, '0);
    wb(14'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    drain();
    do_req(14'd5, 1'b1, 32'hDEAD_BEEF);
    @(negedge aclk); chk("lat_n1_rvalid", 32'(ifc.rvalid), 32'd0);
    @(negedge aclk); chk("lat_n2_rvalid", 32'(ifc.rvalid), 32'd1);
    @(posedge aclk); #1;
    wb(14'd5, '0, 1'b0, 1'b0);
    drain();

    // 2: back-to-back reads of 7; the second waits for the write-back of the first
    do_req(14'd7, 1'b0, '0);
    fork
      do_req(14'd7, 1'b1, 32'h11);
      begin
        repeat (3) begin
          @(negedge aclk); chk("raw_stall", 32'(ifc.req_tready), 32'd0);
        end
        @(posedge aclk); #1;
        ifc.waddr = 14'd7; ifc.wdata = 32'h11; ifc.wstrb = 1'b1; ifc.wvalid = 1'b1;
        @(negedge aclk); chk("raw_pop_cycle_stall", 32'(ifc.req_tready), 32'd0);
        @(posedge aclk); #1;
        ifc.wvalid = 1'b0; ifc.wstrb = 1'b0;
      end
    join
    wb(14'd7, '0, 1'b0, 1'b0);
    drain();

    // 3: consumer stalled with four requests: only two fit, order kept on release
    for (int i = 0; i < 4; i++) begin
      do_req(14'(20 + i), 1'b0, '0);
      wb(14'(20 + i), pat(20 + i), 1'b1, 1'b0);
    end
    drain();
    ifc.rready = 1'b0;
    base = acc_count;
    fork
      for (int i = 0; i < 4; i++) do_req(14'(20 + i), 1'b1, pat(20 + i));
      begin
        repeat (10) @(negedge aclk);
        chk("skid_accepts", 32'(acc_count - base), 32'd2);
        chk("skid_rdata_head", ifc.rdata, pat(20));
        @(posedge aclk); #1;
        ifc.rready = 1'b1;
      end
    join
    for (int i = 0; i < 4; i++) wb(14'(20 + i), 32'hFFFF_FFFF, 1'b0, 1'b0);
    drain();
    do_req(14'd20, 1'b1, pat(20));
    wb(14'd20, '0, 1'b0, 1'b0);
    drain();

    // 4: fill all in-flight entries; the ninth request waits for one retirement
    for (int i = 30; i < 39; i++) begin
      do_req(14'(i), 1'b0, '0);
      wb(14'(i), pat(i), 1'b1, 1'b0);
    end
    drain();
    base = acc_count;
    for (int i = 30; i < 38; i++) do_req(14'(i), 1'b1, pat(i));
    fork
      do_req(14'd38, 1'b1, pat(38));
      begin
        repeat (4) begin
          @(negedge aclk); chk("full_stall", 32'(ifc.req_tready), 32'd0);
        end
        @(posedge aclk); #1;
        wb(14'd30, '0, 1'b0, 1'b0);
      end
    join
    chk("full_accepts", 32'(acc_count - base), 32'd9);
    for (int i = 31; i < 39; i++) wb(14'(i), '0, 1'b0, 1'b0);
    drain();

    // 5: clear with three reads in flight
    do_req(14'd40, 1'b0, '0);
    do_req(14'd41, 1'b0, '0);
    do_req(14'd42, 1'b0, '0);
    ifc.clear_value = 32'hA5A5_A5A5; ifc.clear_start = 1'b1;
    @(posedge aclk); #1;
    ifc.clear_start = 1'b0; ifc.clear_value = '0;
    @(negedge aclk);
    chk("clear_busy_on", 32'(ifc.clear_busy), 32'd1);
    chk("clear_req_block", 32'(ifc.req_tready), 32'd0);
    @(posedge aclk); #1;
    repeat (4) @(posedge aclk);
    #1;
    wb(14'd40, '0, 1'b0, 1'b0);
    wb(14'd41, '0, 1'b0, 1'b0);
    wb(14'd42, '0, 1'b0, 1'b0);
    // One wait cycle after the last retirement, then one cycle per index
    n = 0;
    do begin
      @(negedge aclk);
      if (ifc.clear_busy) n++;
    end while (ifc.clear_busy && n <= DEPTH + 10);
    chk("clear_busy_cycles", 32'(n), 32'(DEPTH + 1));
    @(posedge aclk); #1;
    do_req(14'd0, 1'b1, 32'hA5A5_A5A5);
    do_req(14'd5, 1'b1, 32'hA5A5_A5A5);
    do_req(14'(DEPTH - 1), 1'b1, 32'hA5A5_A5A5);
    wb(14'd0, '0, 1'b0, 1'b0);
    wb(14'd5, '0, 1'b0, 1'b0);
    wb(14'(DEPTH - 1), '0, 1'b0, 1'b0);
    drain();

    // 6: ordering error, frame_done pulse, reset mid-clear
    @(negedge aclk); chk("order_error_clean", 32'(ifc.order_error), 32'd0);
    @(posedge aclk); #1;
    do_req(14'd100, 1'b1, 32'hA5A5_A5A5);
    wb(14'd101, '0, 1'b0, 1'b0);
    @(negedge aclk); chk("order_error_set", 32'(ifc.order_error), 32'd1);
    @(posedge aclk); #1;
    ifc.waddr = 14'd100; ifc.wlast = 1'b1; ifc.wvalid = 1'b1;
    @(negedge aclk); chk("frame_done_pre", 32'(ifc.frame_done), 32'd0);
    @(posedge aclk); #1;
    ifc.wvalid = 1'b0; ifc.wlast = 1'b0;
    @(negedge aclk); chk("frame_done_pulse", 32'(ifc.frame_done), 32'd1);
    @(negedge aclk);
    chk("frame_done_end", 32'(ifc.frame_done), 32'd0);
    chk("order_error_sticky", 32'(ifc.order_error), 32'd1);
    @(posedge aclk); #1;
    drain();
    ifc.clear_value = 32'h3C3C_3C3C; ifc.clear_start = 1'b1;
    @(posedge aclk); #1;
    ifc.clear_start = 1'b0;
    repeat (10) @(posedge aclk);
    #1;
    @(negedge aclk); chk("mid_clear_busy", 32'(ifc.clear_busy), 32'd1);
    @(posedge aclk); #1;
    reset = 1'b1;
    @(negedge aclk);
    chk("rst_clear_busy_mid", 32'(ifc.clear_busy), 32'd0);
    chk("rst_order_error_clr", 32'(ifc.order_error), 32'd0);
    chk("rst_fsm_run", 32'(ifc.fsm_state), 32'd0);
    @(posedge aclk); #1;
    reset = 1'b0;
    @(negedge aclk);
    chk("post_rst_ready", 32'(ifc.req_tready), 32'd1);
    chk("post_rst_busy", 32'(ifc.clear_busy), 32'd0);
    @(posedge aclk); #1;
    // Early indices got the new fill; the far end keeps the previous clear value
    do_req(14'd2, 1'b1, 32'h3C3C_3C3C);
    do_req(14'd16000, 1'b1, 32'hA5A5_A5A5);
    wb(14'd2, '0, 1'b0, 1'b0);
    wb(14'd16000, '0, 1'b0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
